// File: rtl/spi_controller.sv
// SPI mode-0 write initiator: serialises {1'b1, addr[6:0], data[7:0]} MSB first on SCLK/nCS/COPI.
// Latency: done pulses 33*CLK_DIV+GAP_CYCLES cycles after accept; err pulses 1 cycle after accept.
// Backpressure: req_ready is high only while idle; a legal request held during the done cycle starts the next frame on that edge.
module spi_controller #(
   parameter int CLK_DIV    = 4,
   parameter int MAX_ADDR   = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic [6:0] req_addr,
   input  logic [7:0] req_data,
   output logic       req_ready,
   output logic       done,
   output logic       err,
   output logic       SCLK,
   output logic       nCS,
   output logic       COPI
);

   typedef enum logic [2:0] {IDLE, REJECT, SETUP, SHIFT, HOLD, GAP} state_t;

   localparam int CW = $clog2(CLK_DIV + 1);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [6:0]    MAX_A    = 7'(MAX_ADDR);

   state_t        state_q;
   logic [CW-1:0] cnt_q;     // clk cycles within the current half-period / setup / hold
   logic [GW-1:0] gcnt_q;    // clk cycles spent in the inter-frame gap
   logic [3:0]    bit_q;     // index of the bit currently on COPI
   logic [15:0]   sh_q;      // frame shift register, next bit to present is sh_q[14]
   logic          sclk_q, ncs_q, copi_q, done_q, err_q, rdy_q;

   logic [15:0]   frame_d;
   logic          addr_ok_d;

   // Frame image and address legality taken straight from the request inputs
   always_comb begin
      frame_d   = {1'b1, req_addr, req_data};
      addr_ok_d = (req_addr <= MAX_A);
   end

   // Frame sequencer: all SPI pins and handshake outputs are registered here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gcnt_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         sclk_q  <= 1'b0;
         ncs_q   <= 1'b1;
         copi_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  rdy_q <= 1'b0;
                  cnt_q <= '0;
                  if (!addr_ok_d) begin
                     err_q   <= 1'b1;
                     state_q <= REJECT;
                  end else begin
                     sh_q    <= frame_d;
                     ncs_q   <= 1'b0;
                     sclk_q  <= 1'b0;
                     copi_q  <= 1'b1;
                     bit_q   <= '0;
                     state_q <= SETUP;
                  end
               end
            end
            REJECT: begin
               rdy_q   <= 1'b1;
               state_q <= IDLE;
            end
            SETUP: begin
               if (cnt_q == DIV_LAST) begin
                  cnt_q   <= '0;
                  sclk_q  <= 1'b1;
                  state_q <= SHIFT;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            SHIFT: begin
               if (cnt_q == DIV_LAST) begin
                  cnt_q <= '0;
                  if (!sclk_q) begin
                     sclk_q <= 1'b1;
                  end else begin
                     // falling edge ends the current bit; COPI moves only here
                     sclk_q <= 1'b0;
                     sh_q   <= {sh_q[14:0], 1'b0};
                     if (bit_q == 4'd15) begin
                        copi_q  <= 1'b0;
                        state_q <= HOLD;
                     end else begin
                        copi_q <= sh_q[14];
                        bit_q  <= bit_q + 4'd1;
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            HOLD: begin
               if (cnt_q == DIV_LAST) begin
                  cnt_q <= '0;
                  ncs_q <= 1'b1;
                  // with no gap the next request waits one idle cycle so the
                  // peripheral always sees nCS high between frames
                  if (GAP_CYCLES == 0) begin
                     done_q  <= 1'b1;
                     rdy_q   <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     gcnt_q  <= '0;
                     state_q <= GAP;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            GAP: begin
               if (gcnt_q == GAP_LAST) begin
                  done_q <= 1'b1;
                  // a legal request waiting here starts immediately; an illegal
                  // one is left for IDLE so err never coincides with done
                  if (req_valid && addr_ok_d) begin
                     rdy_q   <= 1'b0;
                     cnt_q   <= '0;
                     sh_q    <= frame_d;
                     ncs_q   <= 1'b0;
                     sclk_q  <= 1'b0;
                     copi_q  <= 1'b1;
                     bit_q   <= '0;
                     state_q <= SETUP;
                  end else begin
                     rdy_q   <= 1'b1;
                     state_q <= IDLE;
                  end
               end else begin
                  gcnt_q <= gcnt_q + 1'b1;
               end
            end
            default: begin
               rdy_q   <= 1'b1;
               ncs_q   <= 1'b1;
               sclk_q  <= 1'b0;
               copi_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready = rdy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign SCLK      = sclk_q;
   assign nCS       = ncs_q;
   assign COPI      = copi_q;

endmodule
